tstate_sequencer: RTL and testbench

- Sits directly downstream of the two-phase clock generator and consumes its CLK1/CLK2 phase outputs.
- Resamples both phases into the single system clock domain and edge-detects them.
- Turns the phase edges into a one-hot T-state sequence (T0..T(N-1)) plus a per-state latch strobe.
- Provides run / single-step / halt control for the downstream datapath.

---
 rtl/tstate_sequencer.sv | 150 +++++++++++++++
 tb/tb_tstate_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tstate_sequencer.sv
// T-state sequencer.
// Resamples the two clock-generator phases into the system clock domain, edge-detects them and
// steps a one-hot T-state sequence (T0..T(NSTATES-1)) with run / single-step / halt control.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   ph1_i, ph2_i   phase levels from the clock generator (asynchronous to clk_i)
//   run_i          level, free-run machine cycles while high
//   step_i         one-clock pulse, execute exactly one machine cycle
//   halt_req_i     one-clock pulse, stop at the end of the current machine cycle
//   t_o            one-hot current T-state, zero when idle
//   t_idx_o        binary index of the current T-state
//   latch_o        one-clock strobe on a phase-2 edge inside an active T-state
//   cycle_done_o   one-clock strobe when the last T-state completes
//   busy_o         high while a machine cycle is in progress
//   cycle_cnt_o    completed machine cycles, wraps
//   overlap_err_o  sticky, both phase edges seen in the same clock
module tstate_sequencer #(
  parameter int unsigned NSTATES = 4,
  parameter int unsigned CNTW    = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ph1_i,
  input  logic               ph2_i,
  input  logic               run_i,
  input  logic               step_i,
  input  logic               halt_req_i,
  output logic [NSTATES-1:0] t_o,
  output logic [2:0]         t_idx_o,
  output logic               latch_o,
  output logic               cycle_done_o,
  output logic               busy_o,
  output logic [CNTW-1:0]    cycle_cnt_o,
  output logic               overlap_err_o
);

  localparam logic [2:0] LastIdx = 3'(NSTATES - 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e              state_q;
  logic                ph1_q, ph1_qq, ph2_q, ph2_qq;
  logic                step_mode_q, step_pend_q, halt_pend_q;
  logic [NSTATES-1:0]  t_q;
  logic [2:0]          idx_q;
  logic                latch_q, done_q, busy_q, ovl_q;
  logic [CNTW-1:0]     cnt_q;

  logic ph1_rise, ph2_rise, step_go;

  // Two-flop resampling of each phase.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ph1_q  <= 1'b0;
      ph1_qq <= 1'b0;
      ph2_q  <= 1'b0;
      ph2_qq <= 1'b0;
    end else begin
      ph1_q  <= ph1_i;
      ph1_qq <= ph1_q;
      ph2_q  <= ph2_i;
      ph2_qq <= ph2_q;
    end
  end

  assign ph1_rise = ph1_q & ~ph1_qq;
  assign ph2_rise = ph2_q & ~ph2_qq;
  // A halt request in idle cancels any pending step, including one about to start.
  assign step_go  = step_pend_q & ~halt_req_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      step_mode_q <= 1'b0;
      step_pend_q <= 1'b0;
      halt_pend_q <= 1'b0;
      t_q         <= '0;
      idx_q       <= '0;
      latch_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      ovl_q       <= 1'b0;
    end else begin
      latch_q <= 1'b0;
      done_q  <= 1'b0;
      if (ph1_rise && ph2_rise) begin
        ovl_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (halt_req_i) begin
            step_pend_q <= 1'b0;
          end else if (step_i) begin
            step_pend_q <= 1'b1;
          end
          if (ph1_rise && (run_i || step_go)) begin
            state_q     <= StActive;
            t_q         <= NSTATES'(1);
            idx_q       <= '0;
            busy_q      <= 1'b1;
            step_mode_q <= step_go & ~run_i;
            step_pend_q <= 1'b0;
            halt_pend_q <= 1'b0;
          end
        end
        StActive: begin
          if (halt_req_i) begin
            halt_pend_q <= 1'b1;
          end
          // Phase-1 edges take priority; a coincident phase-2 edge produces no latch.
          if (ph1_rise) begin
            if (idx_q != LastIdx) begin
              idx_q <= idx_q + 3'd1;
              t_q   <= {t_q[NSTATES-2:0], 1'b0};
            end else begin
              done_q <= 1'b1;
              cnt_q  <= cnt_q + CNTW'(1);
              if (halt_pend_q || halt_req_i || step_mode_q || !run_i) begin
                state_q     <= StIdle;
                t_q         <= '0;
                idx_q       <= '0;
                busy_q      <= 1'b0;
                halt_pend_q <= 1'b0;
                step_mode_q <= 1'b0;
              end else begin
                t_q   <= NSTATES'(1);
                idx_q <= '0;
              end
            end
          end else if (ph2_rise) begin
            latch_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign t_o           = t_q;
  assign t_idx_o       = idx_q;
  assign latch_o       = latch_q;
  assign cycle_done_o  = done_q;
  assign busy_o        = busy_q;
  assign cycle_cnt_o   = cnt_q;
  assign overlap_err_o = ovl_q;

endmodule

// File: tb/tb_tstate_sequencer.sv
// Scoreboard bench for tstate_sequencer: directed phase stimulus pushes the hand-derived
// expected output events; a negedge monitor pops and compares every event the DUT presents.
module tb_tstate_sequencer;

  typedef struct packed {
    logic [3:0]  t;
    logic [2:0]  idx;
    logic        latch;
    logic        done;
    logic        busy;
    logic [15:0] cnt;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ph1 = 1'b0, ph2 = 1'b0, run = 1'b0, step = 1'b0, halt = 1'b0;
  logic [3:0]  t;
  logic [2:0]  t_idx;
  logic        latch, done, busy, ovl;
  logic [15:0] cnt;
  logic [3:0]  t_w;
  logic [2:0]  t_idx_w;
  logic        latch_w, done_w, busy_w, ovl_w;
  logic [3:0]  cnt_w;

  int   vectors = 0;
  int   miscompares = 0;
  ev_t  exp_q[$];
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  tstate_sequencer #(.NSTATES(4), .CNTW(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .ph1_i(ph1), .ph2_i(ph2), .run_i(run), .step_i(step),
    .halt_req_i(halt), .t_o(t), .t_idx_o(t_idx), .latch_o(latch), .cycle_done_o(done),
    .busy_o(busy), .cycle_cnt_o(cnt), .overlap_err_o(ovl)
  );

  // Narrow-counter build sharing the same stimulus, used for the wrap check.
  tstate_sequencer #(.NSTATES(4), .CNTW(4)) u_wrap (
    .clk_i(clk), .rst_ni(rst_n), .ph1_i(ph1), .ph2_i(ph2), .run_i(run), .step_i(step),
    .halt_req_i(halt), .t_o(t_w), .t_idx_o(t_idx_w), .latch_o(latch_w),
    .cycle_done_o(done_w), .busy_o(busy_w), .cycle_cnt_o(cnt_w), .overlap_err_o(ovl_w)
  );

  // Monitor: any strobe or change of T/BUSY is an output event.
  logic [3:0] prev_t = '0;
  logic       prev_busy = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    if (mon_en && (latch || done || t != prev_t || busy != prev_busy)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event t=%b idx=%0d latch=%b done=%b busy=%b cnt=%0d, none required",
                 t, t_idx, latch, done, busy, cnt);
      end else begin
        e = exp_q.pop_front();
        if (t !== e.t || t_idx !== e.idx || latch !== e.latch || done !== e.done ||
            busy !== e.busy || cnt !== e.cnt) begin
          miscompares++;
          $display("FAIL event got t=%b idx=%0d latch=%b done=%b busy=%b cnt=%0d, required t=%b idx=%0d latch=%b done=%b busy=%b cnt=%0d",
                   t, t_idx, latch, done, busy, cnt, e.t, e.idx, e.latch, e.done, e.busy, e.cnt);
        end
      end
    end
    prev_t    = t;
    prev_busy = busy;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [3:0] et, input logic [2:0] ei, input logic el, input logic ed,
                      input logic eb, input logic [15:0] ec);
    ev_t e;
    e = '{t: et, idx: ei, latch: el, done: ed, busy: eb, cnt: ec};
    exp_q.push_back(e);
  endtask

  // State-change event, followed by its latch strobe when the sequencer stays active.
  task automatic st(input logic [3:0] et, input logic [2:0] ei, input logic ed, input logic eb,
                    input logic [15:0] ec);
    push(et, ei, 1'b0, ed, eb, ec);
    if (eb) push(et, ei, 1'b1, 1'b0, 1'b1, ec);
  endtask

  // One 8-clock phase period: PH1 high 2 clocks, then PH2 high 2 clocks.
  // With both=1 the two phases rise together.
  task automatic ph_period(input logic both);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ph1 = (i < 2);
      ph2 = both ? (i < 2) : (i >= 3 && i < 5);
    end
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    if (which == 0) step = 1'b1; else halt = 1'b1;
    @(negedge clk);
    step = 1'b0;
    halt = 1'b0;
  endtask

  // n free-running cycles from idle, ending with RUN dropped so the last one returns to idle.
  task automatic run_cycles(input int n, input logic [15:0] base);
    logic [3:0] tt;
    run = 1'b1;
    for (int c = 0; c < n; c++) begin
      for (int k = 0; k < 4; k++) begin
        tt = 4'(1 << k);
        if (k == 0 && c == 0) st(4'b0001, 3'd0, 1'b0, 1'b1, base);
        else if (k == 0)      st(4'b0001, 3'd0, 1'b1, 1'b1, base + 16'(c));
        else                  st(tt, 3'(k), 1'b0, 1'b1, base + 16'(c));
        ph_period(1'b0);
      end
    end
    run = 1'b0;
    st(4'b0000, 3'd0, 1'b1, 1'b0, base + 16'(n));
    ph_period(1'b0);
  endtask

  initial begin
    // Reset and idle
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_t", 32'(t), 0);
    chk("rst_idx", 32'(t_idx), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_latch", 32'(latch), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_ovl", 32'(ovl), 0);
    mon_en = 1'b1;
    rst_n  = 1'b1;
    ph_period(1'b0);
    ph_period(1'b0);
    chk("idle_t", 32'(t), 0);
    chk("idle_busy", 32'(busy), 0);

    // Free run, 3 machine cycles
    run_cycles(3, 16'd0);
    chk("run_cnt", 32'(cnt), 3);
    chk("run_t_after", 32'(t), 0);

    // Single step, with a second STEP while active
    pulse(0);
    st(4'b0001, 3'd0, 1'b0, 1'b1, 16'd3);
    ph_period(1'b0);
    pulse(0);
    st(4'b0010, 3'd1, 1'b0, 1'b1, 16'd3);
    ph_period(1'b0);
    st(4'b0100, 3'd2, 1'b0, 1'b1, 16'd3);
    ph_period(1'b0);
    st(4'b1000, 3'd3, 1'b0, 1'b1, 16'd3);
    ph_period(1'b0);
    st(4'b0000, 3'd0, 1'b1, 1'b0, 16'd4);
    ph_period(1'b0);
    ph_period(1'b0);
    chk("step_cnt", 32'(cnt), 4);
    chk("step_busy", 32'(busy), 0);

    // Halt requested during T1 with RUN held high
    run = 1'b1;
    st(4'b0001, 3'd0, 1'b0, 1'b1, 16'd4);
    ph_period(1'b0);
    st(4'b0010, 3'd1, 1'b0, 1'b1, 16'd4);
    ph_period(1'b0);
    pulse(1);
    st(4'b0100, 3'd2, 1'b0, 1'b1, 16'd4);
    ph_period(1'b0);
    st(4'b1000, 3'd3, 1'b0, 1'b1, 16'd4);
    ph_period(1'b0);
    st(4'b0000, 3'd0, 1'b1, 1'b0, 16'd5);
    ph_period(1'b0);
    run = 1'b0;
    chk("halt_busy", 32'(busy), 0);
    chk("halt_cnt", 32'(cnt), 5);

    // Counter wrap on the 4-bit build
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    chk("wrap_pre", 32'(cnt_w), 0);
    run_cycles(16, 16'd0);
    chk("wrap_cnt16", 32'(cnt), 16);
    chk("wrap_cnt4", 32'(cnt_w), 0);

    // Coincident phase edges: T advances, no latch, sticky error
    run = 1'b1;
    st(4'b0001, 3'd0, 1'b0, 1'b1, 16'd16);
    ph_period(1'b0);
    chk("ovl_before", 32'(ovl), 0);
    push(4'b0010, 3'd1, 1'b0, 1'b0, 1'b1, 16'd16);
    ph_period(1'b1);
    chk("ovl_set", 32'(ovl), 1);
    run = 1'b0;
    st(4'b0100, 3'd2, 1'b0, 1'b1, 16'd16);
    ph_period(1'b0);
    st(4'b1000, 3'd3, 1'b0, 1'b1, 16'd16);
    ph_period(1'b0);
    st(4'b0000, 3'd0, 1'b1, 1'b0, 16'd17);
    ph_period(1'b0);
    chk("ovl_sticky", 32'(ovl), 1);
    chk("ovl_cnt", 32'(cnt), 17);

    // Asynchronous reset during T2
    run = 1'b1;
    st(4'b0001, 3'd0, 1'b0, 1'b1, 16'd17);
    ph_period(1'b0);
    st(4'b0010, 3'd1, 1'b0, 1'b1, 16'd17);
    ph_period(1'b0);
    st(4'b0100, 3'd2, 1'b0, 1'b1, 16'd17);
    ph_period(1'b0);
    @(posedge clk);
    #2;
    push(4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_t", 32'(t), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_cnt", 32'(cnt), 0);
    chk("arst_ovl", 32'(ovl), 0);
    chk("arst_idx", 32'(t_idx), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    st(4'b0001, 3'd0, 1'b0, 1'b1, 16'd0);
    ph_period(1'b0);
    run = 1'b0;
    st(4'b0010, 3'd1, 1'b0, 1'b1, 16'd0);
    ph_period(1'b0);
    st(4'b0100, 3'd2, 1'b0, 1'b1, 16'd0);
    ph_period(1'b0);
    st(4'b1000, 3'd3, 1'b0, 1'b1, 16'd0);
    ph_period(1'b0);
    st(4'b0000, 3'd0, 1'b1, 1'b0, 16'd1);
    ph_period(1'b0);
    chk("restart_cnt", 32'(cnt), 1);

    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
